// File: rtl/i2s_sample_transmitter.sv
// I2S transmitter: rounds/saturates 34-bit interpolated stereo samples to 24-bit PCM
// and serializes them as 512-clk I2S frames (BCLK = clk/8, LRCLK = clk/512).
module i2s_sample_transmitter #(
  parameter int unsigned SHIFT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        din_valid,
  input  logic [33:0] l_data_in,
  input  logic [33:0] r_data_in,
  input  logic        clr_flags,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun
);

  localparam int unsigned IN_W   = 34;
  localparam int unsigned EXT_W  = 35;
  localparam int unsigned PCM_W  = 24;
  localparam int unsigned DIV_W  = 3;
  localparam int unsigned SLOT_W = 6;
  localparam int unsigned K_W    = 5;

  localparam logic signed [EXT_W-1:0] RND     = EXT_W'(1) << (SHIFT - 1);
  localparam logic signed [EXT_W-1:0] PCM_MAX = EXT_W'(24'h7F_FFFF);
  localparam logic signed [EXT_W-1:0] PCM_MIN = ~PCM_MAX;

  // Round-half-up, arithmetic shift, clamp to 24-bit signed range.
  function automatic logic [PCM_W-1:0] f_convert(input logic [IN_W-1:0] d);
    logic signed [EXT_W-1:0] x;
    logic signed [EXT_W-1:0] y;
    x = $signed({d[IN_W-1], d}) + RND;
    y = x >>> SHIFT;
    if (y > PCM_MAX)      return PCM_MAX[PCM_W-1:0];
    else if (y < PCM_MIN) return PCM_MIN[PCM_W-1:0];
    else                  return y[PCM_W-1:0];
  endfunction

  logic [DIV_W-1:0]  r_div;
  logic [SLOT_W-1:0] r_slot;
  logic [PCM_W-1:0]  r_hold_l, r_hold_r, r_shift_l, r_shift_r;
  logic              r_fresh, r_bclk, r_lrclk, r_sdata, r_frame_start, r_underrun, r_overrun;

  logic              w_load;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [PCM_W-1:0]  w_hold_l_nxt, w_hold_r_nxt, w_shift_l_nxt, w_shift_r_nxt, w_word;
  logic [K_W-1:0]    w_k, w_bit_idx;
  logic              w_fresh_nxt, w_sdata_nxt, w_underrun_nxt, w_overrun_nxt;

  // Next-state: dividers, frame load, capture and flag logic.
  always_comb begin
    w_div_nxt     = '0;
    w_slot_nxt    = '0;
    w_shift_l_nxt = '0;
    w_shift_r_nxt = '0;
    w_load        = run && (r_div == 3'd7) && (r_slot == 6'd63);
    if (run) begin
      w_div_nxt     = r_div + 3'd1;
      w_slot_nxt    = (r_div == 3'd7) ? r_slot + 6'd1 : r_slot;
      w_shift_l_nxt = w_load ? r_hold_l : r_shift_l;
      w_shift_r_nxt = w_load ? r_hold_r : r_shift_r;
    end

    w_k         = w_slot_nxt[K_W-1:0];
    w_word      = w_slot_nxt[SLOT_W-1] ? w_shift_r_nxt : w_shift_l_nxt;
    w_bit_idx   = 5'd24 - w_k;
    w_sdata_nxt = ((w_k >= 5'd1) && (w_k <= 5'd24)) ? w_word[w_bit_idx] : 1'b0;

    w_hold_l_nxt = din_valid ? f_convert(l_data_in) : r_hold_l;
    w_hold_r_nxt = din_valid ? f_convert(r_data_in) : r_hold_r;
    w_fresh_nxt  = din_valid ? 1'b1 : (w_load ? 1'b0 : r_fresh);

    w_underrun_nxt = (w_load && !r_fresh) ? 1'b1 : (clr_flags ? 1'b0 : r_underrun);
    w_overrun_nxt  = (din_valid && r_fresh && !w_load) ? 1'b1 : (clr_flags ? 1'b0 : r_overrun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div         <= '0;
      r_slot        <= '0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_shift_l     <= '0;
      r_shift_r     <= '0;
      r_fresh       <= 1'b0;
      r_bclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_slot        <= w_slot_nxt;
      r_hold_l      <= w_hold_l_nxt;
      r_hold_r      <= w_hold_r_nxt;
      r_shift_l     <= w_shift_l_nxt;
      r_shift_r     <= w_shift_r_nxt;
      r_fresh       <= w_fresh_nxt;
      r_bclk        <= w_div_nxt[DIV_W-1];
      r_lrclk       <= w_slot_nxt[SLOT_W-1];
      r_sdata       <= w_sdata_nxt;
      r_frame_start <= w_load;
      r_underrun    <= w_underrun_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  assign i2s_bclk    = r_bclk;
  assign i2s_lrclk   = r_lrclk;
  assign i2s_sdata   = r_sdata;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign overrun     = r_overrun;

endmodule
